// File: rtl/vx_pipe_share_arb_if.sv
// Requester and datapath handshake bundle for vx_pipe_share_arb.
// The arbiter takes the slave view; requesters plus the external datapath take the master view.
interface vx_pipe_share_arb_if #(
  parameter int NUM_REQS  = 4,
  parameter int REQ_DATAW = 32,
  parameter int RSP_DATAW = 32
);
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS*REQ_DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]           req_ready;
  logic                          pipe_enable;
  logic [REQ_DATAW-1:0]          pipe_in_data;
  logic [RSP_DATAW-1:0]          pipe_out_data;
  logic [NUM_REQS-1:0]           rsp_valid;
  logic [RSP_DATAW-1:0]          rsp_data;
  logic [NUM_REQS-1:0]           rsp_ready;

  modport slave (
    input  req_valid, req_data, pipe_out_data, rsp_ready,
    output req_ready, pipe_enable, pipe_in_data, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_data, pipe_out_data, rsp_ready,
    input  req_ready, pipe_enable, pipe_in_data, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vx_pipe_share_arb.sv
// Round-robin sharing of one fixed-latency, enable-gated datapath among NUM_REQS requesters.
// A tag/valid shadow pipeline follows each request so its result is steered back to its owner.
module vx_pipe_share_arb #(
  parameter int NUM_REQS  = 4,
  parameter int LATENCY   = 3,
  parameter int REQ_DATAW = 32,
  parameter int RSP_DATAW = 32,
  localparam int TAGW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNTW = $clog2(LATENCY + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_pipe_share_arb_if.slave     bus,
  output logic [CNTW-1:0]        pending
);

  logic [LATENCY-1:0]           vld_q, vld_d;
  logic [LATENCY-1:0][TAGW-1:0] tag_q, tag_d;
  logic [TAGW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]              pending_q, pending_d;

  logic            tail_vld_s;
  logic [TAGW-1:0] tail_tag_s;
  logic            enable_s;
  logic            any_req_s;
  logic            found_s;
  logic [TAGW-1:0] grant_s;
  logic            accept_s;

  // Tail status: an undeliverable tail result freezes every stage
  always_comb begin
    tail_vld_s = vld_q[LATENCY-1];
    tail_tag_s = tag_q[LATENCY-1];
    enable_s   = ~(tail_vld_s & ~bus.rsp_ready[tail_tag_s]);
  end

  // Round-robin scan starting at rr_ptr; nothing is offered while reset is held
  always_comb begin
    grant_s   = rr_ptr_q;
    found_s   = 1'b0;
    any_req_s = (|bus.req_valid) & reset;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!found_s && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQS]) begin
        grant_s = TAGW'((int'(rr_ptr_q) + k) % NUM_REQS);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    accept_s = enable_s & any_req_s;
  end

  // Acceptance strobe and payload steering into datapath stage 0
  always_comb begin
    bus.req_ready = '0;
    if (accept_s) begin
      bus.req_ready[grant_s] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
    if (any_req_s) begin
      bus.pipe_in_data = bus.req_data[grant_s*REQ_DATAW +: REQ_DATAW];
    end else begin
      bus.pipe_in_data = '0;
    end
    bus.pipe_enable = enable_s;
  end

  // Result steering from the tail to its owner; payload passes straight through
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.rsp_valid[i] = tail_vld_s & (tail_tag_s == TAGW'(i));
    end
    bus.rsp_data = bus.pipe_out_data;
  end

  // Shadow pipeline advance; bubbles shift like data and everything holds on stall
  always_comb begin
    vld_d     = vld_q;
    tag_d     = tag_q;
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    if (enable_s) begin
      vld_d[0] = any_req_s;
      tag_d[0] = grant_s;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      if (any_req_s) begin
        rr_ptr_d = (grant_s == TAGW'(NUM_REQS - 1)) ? '0 : grant_s + TAGW'(1);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      // while enabled a valid tail is always delivered this cycle
      pending_d = pending_q + CNTW'(accept_s) - CNTW'(tail_vld_s);
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers; reset discards all in-flight work
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_vx_pipe_share_arb.sv
// Self-checking bench for vx_pipe_share_arb: cycle vector table, hand sequences and a
// scoreboard that pairs every accepted request with exactly one result.
module tb_vx_pipe_share_arb;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] pending;
  logic [DW-1:0] dp [L];

  int errors = 0;
  int checks = 0;

  vx_pipe_share_arb_if #(.NUM_REQS(N), .REQ_DATAW(DW), .RSP_DATAW(DW)) bus_if ();

  vx_pipe_share_arb #(.NUM_REQS(N), .LATENCY(L), .REQ_DATAW(DW), .RSP_DATAW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .pending (pending)
  );

  always #5 clk = ~clk;

  // external datapath model: L enable-gated stages, result = data + 1
  always @(posedge clk) begin
    if (bus_if.pipe_enable) begin
      dp[0] <= bus_if.pipe_in_data;
      for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
    end
  end
  assign bus_if.pipe_out_data = dp[L-1] + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb [$];

  // scoreboard: pop on delivery, push on acceptance, sampled away from the clock edge
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      sb.delete();
    end else begin
      chk("pending_vs_inflight", 64'(pending), 64'(sb.size()));
      chk("rsp_valid_onehot", 64'($countones(bus_if.rsp_valid) <= 1), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (bus_if.rsp_valid[i] && bus_if.rsp_ready[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: requester %0d got %0h, required nothing in flight", i, bus_if.rsp_data);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", 64'(i), 64'(e.idx));
            chk("rsp_data", 64'(bus_if.rsp_data), 64'(e.data));
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus_if.req_ready[i] && bus_if.req_valid[i]) begin
          e.idx  = 2'(i);
          e.data = bus_if.req_data[i*DW +: DW] + 32'd1;
          sb.push_back(e);
        end
      end
    end
  end

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    logic [3:0] rr;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rvld;
    logic       exp_en;
    logic [1:0] exp_pend;
  } vec_t;
  vec_t vecs [$];

  function automatic vec_t mk(bit rst, logic [3:0] rv, logic [3:0] rr, logic [3:0] rdy,
                              logic [3:0] rvld, logic en, logic [1:0] pend);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rr = rr; v.exp_rdy = rdy;
    v.exp_rvld = rvld; v.exp_en = en; v.exp_pend = pend;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus_if.req_valid = 4'b0000;
    bus_if.rsp_ready = 4'b1111;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d1;

    // fairness, grants 0..3 twice then drain
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'd0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0));
    // stall on tail tag 1 for two cycles, then resume with no skipped grant
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'd0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1101, 4'b0000, 4'b0010, 1'b0, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1101, 4'b0000, 4'b0010, 1'b0, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0));
    // head-of-line: tail tag 2 blocked blocks requester 0
    vecs.push_back(mk(1, 4'b0100, 4'b1111, 4'b0100, 4'b0000, 1'b1, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0001, 4'b1011, 4'b0000, 4'b0100, 1'b0, 2'd1));
    vecs.push_back(mk(0, 4'b0001, 4'b1011, 4'b0000, 4'b0100, 1'b0, 2'd1));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 4'b0001, 4'b0100, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0));
    // accept and deliver together while two are in flight
    vecs.push_back(mk(1, 4'b0001, 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'd0));
    vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b0010, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b0100, 4'b1111, 4'b0100, 4'b0001, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0));

    bus_if.req_valid = 4'b1111;
    bus_if.rsp_ready = 4'b1111;
    bus_if.req_data  = '0;
    reset = 1'b0;

    // reset state, with requests already offered
    @(negedge clk);
    chk("reset_req_ready", 64'(bus_if.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("reset_pipe_enable", 64'(bus_if.pipe_enable), 64'd1);
    chk("reset_pending", 64'(pending), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_if.req_valid = 4'b0000;

    // single request latency from requester 1
    d1 = 32'hA5A5_0001;
    bus_if.req_valid = 4'b0010;
    bus_if.req_data  = {32'h0, 32'h0, d1, 32'h0};
    @(negedge clk);
    chk("t1_req_ready", 64'(bus_if.req_ready), 64'h2);
    chk("t1_pipe_in", 64'(bus_if.pipe_in_data), 64'(d1));
    @(posedge clk);
    #1;
    bus_if.req_valid = 4'b0000;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      chk("t1_pending", 64'(pending), 64'd1);
      chk("t1_rsp_valid", 64'(bus_if.rsp_valid), (c == L) ? 64'h2 : 64'h0);
      if (c == L) chk("t1_rsp_data", 64'(bus_if.rsp_data), 64'(d1 + 32'd1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t1_pending_end", 64'(pending), 64'd0);
    chk("t1_rsp_end", 64'(bus_if.rsp_valid), 64'd0);
    @(posedge clk);
    #1;

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst) do_reset();
      bus_if.req_valid = vecs[r].rv;
      bus_if.rsp_ready = vecs[r].rr;
      bus_if.req_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", r), 64'(bus_if.req_ready), 64'(vecs[r].exp_rdy));
      chk($sformatf("vec%0d_rsp_valid", r), 64'(bus_if.rsp_valid), 64'(vecs[r].exp_rvld));
      chk($sformatf("vec%0d_pipe_enable", r), 64'(bus_if.pipe_enable), 64'(vecs[r].exp_en));
      chk($sformatf("vec%0d_pending", r), 64'(pending), 64'(vecs[r].exp_pend));
      @(posedge clk);
      #1;
    end

    // asynchronous reset with three in flight
    do_reset();
    bus_if.req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #3;
    chk("t5_pending_before", 64'(pending), 64'd3);
    reset = 1'b0;
    #1;
    chk("t5_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("t5_pending", 64'(pending), 64'd0);
    chk("t5_pipe_enable", 64'(bus_if.pipe_enable), 64'd1);
    chk("t5_req_ready", 64'(bus_if.req_ready), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_first_grant", 64'(bus_if.req_ready), 64'h1);
    @(posedge clk);
    #1;

    // random soak against the scoreboard
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus_if.req_valid = 4'($urandom);
      bus_if.rsp_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      bus_if.req_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    bus_if.req_valid = 4'b0000;
    bus_if.rsp_ready = 4'b1111;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("soak_drained", 64'(sb.size()), 64'd0);
    chk("soak_pending", 64'(pending), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
